// File: rtl/smg_scan_mux_if.sv
// smg_scan_mux_if -- display-driver bus between the data registers and the
// self-scanning 7-segment driver.
//   master : drives the sources and display options, receives seg/an/frame_done
//   slave  : the scan driver itself
// Signals:
//   ch_sel     [CW]                  source channel select
//   data_in    [CHANNELS*DIGITS*4]   packed sources, channel c at [c*DIGITS*4 +: DIGITS*4]
//   dp_mask    [DIGITS]              decimal point per digit
//   blank_lz                         leading-zero blanking enable
//   blink_mask [DIGITS]              per-digit blink (only with SMG_BLINK_EN)
//   seg        [8]                   {dp,g,f,e,d,c,b,a}
//   an         [AW]                  binary index of the active digit
//   frame_done                       one-clock end-of-frame pulse
// Optional feature macro: SMG_BLINK_EN
interface smg_scan_mux_if #(
  parameter int DIGITS   = 8,
  parameter int CHANNELS = 4
);
  localparam int AW = $clog2(DIGITS);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CW-1:0]                ch_sel;
  logic [CHANNELS*DIGITS*4-1:0] data_in;
  logic [DIGITS-1:0]            dp_mask;
  logic                         blank_lz;
`ifdef SMG_BLINK_EN
  logic [DIGITS-1:0]            blink_mask;
`endif
  logic [7:0]                   seg;
  logic [AW-1:0]                an;
  logic                         frame_done;

`ifdef SMG_BLINK_EN
  modport master (output ch_sel, data_in, dp_mask, blank_lz, blink_mask,
                  input  seg, an, frame_done);
  modport slave  (input  ch_sel, data_in, dp_mask, blank_lz, blink_mask,
                  output seg, an, frame_done);
`else
  modport master (output ch_sel, data_in, dp_mask, blank_lz,
                  input  seg, an, frame_done);
  modport slave  (input  ch_sel, data_in, dp_mask, blank_lz,
                  output seg, an, frame_done);
`endif
endinterface

// File: rtl/smg_scan_mux.sv
// smg_scan_mux -- self-scanning, time-multiplexed 7-segment display driver.
// A prescaler holds each digit for SCAN_DIV clocks; a digit counter walks
// 0..DIGITS-1. The selected source, decimal points and blanking option are
// snapshotted at each frame boundary (and on the first clock after reset) so a
// frame never mixes two sources. Digit 0 is the most significant nibble.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    smg_scan_mux_if.slave (sources/options in, seg/an/frame_done out)
// Optional feature macro: SMG_BLINK_EN (adds blink_mask and BLINK_FRAMES)
module smg_scan_mux #(
  parameter int DIGITS         = 8,
  parameter int CHANNELS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 0
`ifdef SMG_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input logic          clk,
  input logic          rst_n,
  smg_scan_mux_if.slave bus
);
  localparam int AW   = $clog2(DIGITS);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW   = DIGITS * 4;
  localparam int CNTW = $clog2(SCAN_DIV);
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [CNTW-1:0]   cnt;
  logic [AW-1:0]     idx;
  logic              primed;
  logic [NW-1:0]     snap_data;
  logic [DIGITS-1:0] snap_dp;
  logic              snap_blz;
  logic [7:0]        seg_q;
  logic [AW-1:0]     an_q;
  logic              frame_done_q;

  logic              tick;
  logic              frame_end;
  logic              snap_load;
  logic              blink_hide;
  logic [NW-1:0]     sel_data;
  logic [NW-1:0]     upper;
  logic [3:0]        nib;
  logic [7:0]        seg_raw;
  logic [7:0]        seg_nxt;
  int                sh;

  assign tick      = (cnt == CNTW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == AW'(DIGITS - 1));
  // Before the first snapshot the display would show reset zeros for a whole
  // frame; loading on the first clock keeps that down to one clock.
  assign snap_load = frame_end || !primed;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    sel_data = bus.data_in[0 +: NW];
    for (int c = 1; c < CHANNELS; c++) begin
      if (bus.ch_sel == CW'(c)) sel_data = bus.data_in[c*NW +: NW];
    end
  end

  // Shifting the snapshot right so the active digit lands in [3:0] leaves
  // exactly that digit and the more significant ones in 'upper': the digit
  // is a leading zero iff 'upper' is all zero.
  always_comb begin
    sh    = 4 * (DIGITS - 1 - int'(idx));
    upper = snap_data >> sh;
    nib   = upper[3:0];
    case (nib)
      4'd0:    seg_raw = 8'h3F;
      4'd1:    seg_raw = 8'h06;
      4'd2:    seg_raw = 8'h5B;
      4'd3:    seg_raw = 8'h4F;
      4'd4:    seg_raw = 8'h66;
      4'd5:    seg_raw = 8'h6D;
      4'd6:    seg_raw = 8'h7D;
      4'd7:    seg_raw = 8'h07;
      4'd8:    seg_raw = 8'h7F;
      4'd9:    seg_raw = 8'h6F;
      default: seg_raw = 8'h40;
    endcase
    seg_raw[7] = snap_dp[idx];
    if (snap_blz && (idx != AW'(DIGITS - 1)) && (upper == '0)) seg_raw = 8'h00;
    if (blink_hide) seg_raw = 8'h00;
    seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      primed       <= 1'b0;
      snap_data    <= '0;
      snap_dp      <= '0;
      snap_blz     <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == AW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      primed       <= 1'b1;
      frame_done_q <= frame_end;
      if (snap_load) begin
        snap_data <= sel_data;
        snap_dp   <= bus.dp_mask;
        snap_blz  <= bus.blank_lz;
      end
      seg_q <= seg_nxt;
      an_q  <= idx;
    end
  end

`ifdef SMG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0]     fcnt;
  logic              blink_off;
  logic [DIGITS-1:0] snap_blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt       <= '0;
      blink_off  <= 1'b0;
      snap_blink <= '0;
    end else begin
      if (frame_end) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt      <= '0;
          blink_off <= ~blink_off;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
      if (snap_load) snap_blink <= bus.blink_mask;
    end
  end

  assign blink_hide = blink_off && snap_blink[idx];
`else
  assign blink_hide = 1'b0;
`endif

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
endmodule
